// File: rtl/bab_pkg.sv
// Shared constants and state type for the bab_2_3_5 generator and its inverse.
// f(n)=2n^2+3n+5 is built from SEED and STEP on both ends.
package bab_pkg;
  localparam int SEED  = 5;
  localparam int STEP  = 4;
  localparam int N_MAX = 63;
  localparam int W_VAL = 13;
  localparam int W_N   = 6;
  localparam int W_F   = W_VAL + 1;

  typedef enum logic [1:0] {
    e_idle,
    e_calc,
    e_done
  } t_state;
endpackage

// File: rtl/bab_2_3_5_inv.sv
// Inverse of the bab_2_3_5 sequence: largest n with f(n) <= value,
// found by stepping the generator one index per cycle.
module bab_2_3_5_inv
  import bab_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [W_VAL-1:0] i_val,
  output logic             o_done,
  output logic [W_N-1:0]   o_n,
  output logic             o_exact,
  output logic             o_under
);

  t_state           r_state;
  logic [W_VAL-1:0] r_val;
  logic [W_N-1:0]   r_n;
  logic [W_F-1:0]   r_f;
  logic [W_F-1:0]   r_d;
  logic [W_F-1:0]   w_val;

  assign w_val = {1'b0, r_val};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= e_idle;
      r_val   <= '0;
      r_n     <= '0;
      r_f     <= '0;
      r_d     <= '0;
      o_done  <= 1'b0;
      o_n     <= '0;
      o_exact <= 1'b0;
      o_under <= 1'b0;
    end else begin
      case (r_state)
        e_idle: begin
          if (i_start) begin
            r_val   <= i_val;
            r_n     <= '0;
            r_f     <= W_F'(SEED);
            r_d     <= W_F'(SEED);
            r_state <= e_calc;
          end
        end
        e_calc: begin
          if (r_f > w_val) begin
            // overshoot: the previous index was the last one <= value
            o_n     <= (r_n == '0) ? '0 : r_n - 1'b1;
            o_under <= (r_n == '0);
            o_exact <= 1'b0;
            o_done  <= 1'b1;
            r_state <= e_done;
          end else if (r_f == w_val) begin
            o_n     <= r_n;
            o_exact <= 1'b1;
            o_under <= 1'b0;
            o_done  <= 1'b1;
            r_state <= e_done;
          end else if (r_n == W_N'(N_MAX)) begin
            o_n     <= r_n;
            o_exact <= 1'b0;
            o_under <= 1'b0;
            o_done  <= 1'b1;
            r_state <= e_done;
          end else begin
            r_f <= r_f + r_d;
            r_d <= r_d + W_F'(STEP);
            r_n <= r_n + 1'b1;
          end
        end
        e_done: begin
          if (i_clear) begin
            o_done  <= 1'b0;
            r_state <= e_idle;
          end
        end
        default: begin
          o_done  <= 1'b0;
          r_state <= e_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bab_2_3_5_inv.sv
// Scoreboard bench for bab_2_3_5_inv: directed corners, round trip
// over every f(n), and random values against an arithmetic model.
module tb_bab_2_3_5_inv;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_clear = 1'b0;
  logic [12:0] i_val = '0;
  logic        o_done;
  logic [5:0]  o_n;
  logic        o_exact;
  logic        o_under;

  bab_2_3_5_inv dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_clear (i_clear),
    .i_val   (i_val),
    .o_done  (o_done),
    .o_n     (o_n),
    .o_exact (o_exact),
    .o_under (o_under)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int v;
    int n;
    bit ex;
    bit un;
    int t;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic int f_of(input int n);
    return 2 * n * n + 3 * n + 5;
  endfunction

  function automatic exp_t model(input int v, input int t);
    exp_t e;
    e.v = v;
    e.t = t;
    if (v < 5) begin
      e.n = 0; e.ex = 0; e.un = 1; e.lat = 2;
    end else begin
      e.n = 0;
      while (e.n < 63 && f_of(e.n + 1) <= v) e.n++;
      e.ex = (f_of(e.n) == v);
      e.un = 0;
      if (e.ex) e.lat = e.n + 2;
      else if (e.n == 63) e.lat = 65;
      else e.lat = e.n + 3;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // monitor: pops one expectation per rising edge of o_done
  logic prev_done = 1'b0;
  always @(negedge i_clk) begin
    exp_t e;
    if (o_done && !prev_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("n v=%0d", e.v), o_n, e.n);
        chk($sformatf("exact v=%0d", e.v), o_exact, e.ex);
        chk($sformatf("under v=%0d", e.v), o_under, e.un);
        chk($sformatf("latency v=%0d", e.v), cyc - e.t, e.lat);
      end
    end
    prev_done <= o_done;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input int v);
    i_val = 13'(v);
    i_start = 1'b1;
    exp_q.push_back(model(v, cyc));
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!o_done && k < 200) begin
      tick();
      k++;
    end
    if (!o_done) chk("done_timeout", 0, 1);
  endtask

  task automatic clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic run(input int v);
    issue(v);
    wait_done();
    clear();
  endtask

  initial begin
    exp_t e;
    repeat (3) tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_done", o_done, 0);
    chk("rst_n", o_n, 0);
    chk("rst_exact", o_exact, 0);
    chk("rst_under", o_under, 0);
    tick();

    run(32);
    run(25);
    run(4);
    run(5);
    run(0);
    run(8132);
    run(8191);
    run(8131);

    // start pulses during CALC must be ignored
    issue(10);
    i_start = 1'b1;
    i_val = 13'd3000;
    tick();
    i_start = 1'b0;
    wait_done();

    // start and clear together in DONE: clear wins, start taken next cycle
    i_clear = 1'b1;
    i_start = 1'b1;
    i_val = 13'd19;
    tick();
    i_clear = 1'b0;
    exp_q.push_back(model(19, cyc));
    tick();
    i_start = 1'b0;
    wait_done();
    clear();

    // reset mid-search discards the result and the pending expectation
    issue(8000);
    repeat (20) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    e = exp_q.pop_back();
    @(negedge i_clk);
    chk("midrst_done", o_done, 0);
    chk("midrst_n", o_n, 0);
    chk("midrst_exact", o_exact, 0);
    chk("midrst_under", o_under, 0);
    tick();
    run(19);

    for (int n = 0; n < 64; n++) run(f_of(n));

    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) run(int'($urandom_range(0, 12)));
      else run(int'($urandom_range(0, 8191)));
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bab_2_3_5_inv.md
Name: bab_2_3_5_inv

Overview:
Inverse of the bab_2_3_5 sequence generator, whose sequence is f(0)=5, f(n+1)=f(n)+d(n), d(0)=5, d(n+1)=d(n)+4, i.e. f(n)=2n²+3n+5.
- Given a 13-bit value, returns the largest index n (0..63) with f(n) <= value.
- Flags whether the match is exact, and flags when the value is below f(0).
- Uses the same start/done/clear handshake as the generator, so the two can be chained for round-trip self-checks on the board.

Parameters:
None. Widths are fixed by the generator: 13-bit value, 6-bit index, N_MAX=63. f(63)=8132 fits in 13 bits; f(64)=8389 does not.

Ports:
i_clk    input   1   clock, rising edge
i_rst    input   1   synchronous, active-high reset
i_start  input   1   start request, sampled only in IDLE
i_clear  input   1   acknowledge result, sampled only in DONE
i_val    input   13  value to invert, latched on accepted start
o_done   output  1   result valid, high for every cycle in DONE
o_n      output  6   largest n with f(n) <= latched value
o_exact  output  1   f(o_n) == latched value
o_under  output  1   latched value < 5; o_n forced to 0

Behaviour:
- Reset: synchronous, i_rst high at a rising edge.
  - State goes to IDLE.
  - o_done, o_n, o_exact, o_under and all internal registers go to 0.
  - Applies in any state, including mid-CALC; the in-progress search is discarded.
- Registers:
  - r_val (13 bits): latched input.
  - r_n (6 bits): current index.
  - r_f and r_d (14 bits each): one bit of headroom so f(n)+d never wraps before the compare.
  - Result registers drive the outputs directly; no combinational path from inputs to outputs.
- IDLE:
  - On i_start: r_val=i_val, r_n=0, r_f=5, r_d=5, go to CALC.
  - i_clear is ignored in IDLE.
- CALC: evaluate one index per cycle, conditions checked in priority order:
  1. r_f > r_val:
     - if r_n==0: o_n=0, o_under=1, o_exact=0;
     - else: o_n=r_n-1, o_exact=0, o_under=0.
     - Go to DONE.
  2. r_f == r_val: o_n=r_n, o_exact=1, o_under=0; go to DONE.
  3. r_n == 63: o_n=63, o_exact=0, o_under=0; go to DONE. This is saturation for values 8133..8191.
  4. Otherwise: r_f += r_d, r_d += 4, r_n += 1; stay in CALC.
  - i_start and i_clear are ignored in CALC.
- DONE:
  - o_done=1; result outputs are held stable.
  - On i_clear: go to IDLE on the next cycle, o_done=0 from then on.
  - Result outputs keep their last value until the next search completes or reset.
  - i_start is ignored in DONE.
- Latency, with start accepted in cycle T:
  - exact n: o_done first high at T+n+2;
  - non-exact n: o_done first high at T+n+3;
  - underflow: T+2;
  - saturation: T+65.
- Simultaneous i_start and i_clear in DONE: only i_clear acts, so the block goes to IDLE. A start held high is accepted in the following IDLE cycle.
- Unreachable/illegal state encoding: next state is IDLE.

Decomposition:
- Package bab_pkg holds:
  - typedef enum t_state {e_idle, e_calc, e_done};
  - localparams SEED=5, STEP=4, N_MAX=63, W_VAL=13, W_N=6.
- bab_2_3_5 moves its 5/4 constants into the same package so both ends share them.
- No sub-module: a single FSMD; the datapath is two adders and two comparators.
- The bench may instantiate bab_2_3_5 as a reference model.

Test Plan:
- i_val=32, start at T -> o_done rises T+5, o_n=3, o_exact=1, o_under=0.
- i_val=25 -> o_done rises T+5, o_n=2, o_exact=0, o_under=0.
- i_val=4 -> o_done rises T+2, o_n=0, o_exact=0, o_under=1. Also i_val=5 -> T+2, o_n=0, o_exact=1.
- Boundary values:
  - i_val=8132 -> T+65, o_n=63, o_exact=1;
  - i_val=8191 -> T+65, o_n=63, o_exact=0.
- Handshake, i_val=10:
  - pulse i_start again during CALC -> ignored, result o_n=1, o_exact=1;
  - hold i_start and i_clear together in DONE -> IDLE for one cycle, then restart with the new i_val.
- Reset and round trip:
  - i_rst pulsed mid-CALC (i_val=8000, 20 cycles in) -> next cycle IDLE, all outputs 0; a new start with i_val=19 gives o_n=2, o_exact=1.
  - Round trip: for all n=0..63, feed bab_2_3_5 output into this block -> o_n==n, o_exact=1.
